// File: rtl/multiply_unit.sv
// multiply_unit: HI/LO multiply/divide unit.
// Multiplies take 5 cycles, divides take 10 cycles; mthi/mtlo write in a single cycle.
// Configuration: define MULTIPLY_UNIT_DIVIDE_EN to build the divider (div/divu).
//   When it is undefined, div/divu are ignored like reserved op codes.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   mulCtrl    - op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   mulEnable  - request strobe
//   operandA   - rs operand (multiplicand / dividend / mthi-mtlo source)
//   operandB   - rt operand (multiplier / divisor)
//   busy       - multiply or divide in progress
//   hi, lo     - HI/LO result registers
module multiply_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mulCtrl,
    input  logic        mulEnable,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] MUL_CYCLES = CNT_W'(5);
    localparam logic [CNT_W-1:0] DIV_CYCLES = CNT_W'(10);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   op_a_q;
    logic [XLEN-1:0]   op_b_q;
    logic              signed_q;
    logic              busy_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;

    logic              accept_c;
    logic [2*XLEN-1:0] mul_a_ext_c;
    logic [2*XLEN-1:0] mul_b_ext_c;
    logic [2*XLEN-1:0] mul_prod_c;

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Requests are only taken in IDLE; op codes without an implementation are dropped.
    always_comb begin
        accept_c = 1'b0;
        if (mulEnable && !busy_q) begin
            case (mulCtrl)
                OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO: accept_c = 1'b1;
`ifdef MULTIPLY_UNIT_DIVIDE_EN
                OP_DIV, OP_DIVU:                     accept_c = 1'b1;
`endif
                default:                             accept_c = 1'b0;
            endcase
        end
    end

    // Sign- or zero-extend to 64 bits so one unsigned multiply covers mult and multu.
    always_comb begin
        mul_a_ext_c = {{XLEN{signed_q & op_a_q[XLEN-1]}}, op_a_q};
        mul_b_ext_c = {{XLEN{signed_q & op_b_q[XLEN-1]}}, op_b_q};
        mul_prod_c  = mul_a_ext_c * mul_b_ext_c;
    end

`ifdef MULTIPLY_UNIT_DIVIDE_EN
    logic [XLEN-1:0] abs_a_c;
    logic [XLEN-1:0] abs_b_c;
    logic [XLEN-1:0] uquo_c;
    logic [XLEN-1:0] urem_c;
    logic [XLEN-1:0] div_quo_c;
    logic [XLEN-1:0] div_rem_c;

    // Divide magnitudes, then restore signs: quotient truncates toward zero,
    // remainder takes the dividend's sign. 0x80000000/-1 falls out as 0x80000000 r 0.
    always_comb begin
        abs_a_c   = (signed_q && op_a_q[XLEN-1]) ? XLEN'(-op_a_q) : op_a_q;
        abs_b_c   = (signed_q && op_b_q[XLEN-1]) ? XLEN'(-op_b_q) : op_b_q;
        uquo_c    = '0;
        urem_c    = '0;
        div_quo_c = '1;
        div_rem_c = op_a_q;
        if (op_b_q != '0) begin
            uquo_c    = abs_a_c / abs_b_c;
            urem_c    = abs_a_c % abs_b_c;
            div_quo_c = (signed_q && (op_a_q[XLEN-1] ^ op_b_q[XLEN-1])) ? XLEN'(-uquo_c) : uquo_c;
            div_rem_c = (signed_q && op_a_q[XLEN-1]) ? XLEN'(-urem_c) : urem_c;
        end
    end
`endif

    // Control FSM, operand latches and HI/LO update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            signed_q <= 1'b0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        case (mulCtrl)
                            OP_MULT, OP_MULTU: begin
                                op_a_q   <= operandA;
                                op_b_q   <= operandB;
                                signed_q <= (mulCtrl == OP_MULT);
                                cnt_q    <= MUL_CYCLES;
                                busy_q   <= 1'b1;
                                state_q  <= MUL;
                            end
`ifdef MULTIPLY_UNIT_DIVIDE_EN
                            OP_DIV, OP_DIVU: begin
                                op_a_q   <= operandA;
                                op_b_q   <= operandB;
                                signed_q <= (mulCtrl == OP_DIV);
                                cnt_q    <= DIV_CYCLES;
                                busy_q   <= 1'b1;
                                state_q  <= DIV;
                            end
`endif
                            OP_MTHI: hi_q <= operandA;
                            OP_MTLO: lo_q <= operandA;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= mul_prod_c[2*XLEN-1:XLEN];
                        lo_q    <= mul_prod_c[XLEN-1:0];
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DIV: begin
`ifdef MULTIPLY_UNIT_DIVIDE_EN
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= div_rem_c;
                        lo_q    <= div_quo_c;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
`else
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`endif
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/multiply_unit.md
MULTIPLY_UNIT -- requirements
Module: multiply_unit

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-low; low clears all state immediately, independent of clk.
REQ-003 SHALL: mulCtrl  in  3  op code: 0 disabled, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (ignored).
REQ-004 SHALL: mulEnable  in  1  request strobe; high means mulCtrl holds a valid op this cycle.
REQ-005 SHALL: operandA  in  32  rs value (multiplicand / dividend / mthi-mtlo source).
REQ-006 SHALL: operandB  in  32  rt value (multiplier / divisor).
REQ-007 SHALL: busy  out  1  high while a multiply or divide is in progress.
REQ-008 SHALL: hi  out  32  HI register, directly readable by mfhi.
REQ-009 SHALL: lo  out  32  LO register, directly readable by mflo.

Function
REQ-010 SHALL: FSM states IDLE, MUL, DIV; reset state IDLE.
REQ-011 SHALL: request accepted on an edge where mulEnable=1, busy=0 and mulCtrl is in 1..6; operandA/operandB latched at that edge.
REQ-012 SHALL: mulEnable=1 while busy=1 is ignored (no latch, no state change); issuing stage stalls on busy.
REQ-013 SHALL: mult/multu accepted at edge E -> MUL, busy=1 for exactly 5 cycles; at edge E+5 {hi,lo} <= 64-bit product, busy->0, state->IDLE.
REQ-014 SHALL: mult treats operands as two's-complement; multu as unsigned; full 64-bit result, hi = bits 63:32, lo = bits 31:0.
REQ-015 SHALL: div/divu accepted at edge E -> DIV, busy=1 for exactly 10 cycles; at edge E+10 lo <= quotient, hi <= remainder, busy->0, state->IDLE.
REQ-016 SHALL: div signed, quotient truncated toward zero, remainder sign follows dividend; divu unsigned.
REQ-017 SHALL: divisor zero -> full latency still observed; result lo=32'hFFFFFFFF, hi=latched dividend.
REQ-018 SHALL: div 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0, no trap.
REQ-019 SHALL: mthi/mtlo accepted at edge E write hi (resp. lo) <= operandA at E; busy stays 0; other register unchanged.
REQ-020 SHALL: hi/lo hold previous values throughout busy; never partially updated.
REQ-021 SHALL: cycle count via 4-bit down-counter loaded at acceptance; completion when counter reaches 1 in MUL/DIV.
REQ-022 SHALL: a new request presented in the cycle busy falls (same edge as completion) is not accepted; earliest acceptance is the next edge.
REQ-023 SHALL: mulCtrl 0 or 7 with mulEnable=1 -> no effect.

Reset
REQ-024 SHALL: reset low -> busy=0, hi=0, lo=0, state IDLE, counter 0, latched operands 0, asynchronously.
REQ-025 SHALL: reset asserted mid-operation aborts it; no result written after reset release.
REQ-026 SHALL: first request accepted on the first rising edge with reset high.

Configuration
REQ-027 SHALL: macro MULTIPLY_UNIT_DIVIDE_EN defined -> div/divu behave per REQ-015..018.
REQ-028 SHALL: macro MULTIPLY_UNIT_DIVIDE_EN undefined -> no divider logic; div/divu treated as REQ-023 (ignored, busy stays 0, hi/lo unchanged); DIV state unreachable.

Verification
REQ-029 SHALL: mult A=32'hFFFFFFFE, B=3 -> busy high 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
REQ-030 SHALL: multu A=32'hFFFFFFFF, B=32'hFFFFFFFF -> after 5 cycles hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-031 SHALL: div A=-7 (32'hFFFFFFF9), B=2 -> busy 10 cycles, lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; divu A=7, B=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-032 SHALL: mthi 32'h12345678 then mtlo 32'h9ABCDEF0 on consecutive edges -> hi/lo hold those values, busy never asserted.
REQ-033 SHALL: mult accepted, second mult held on inputs while busy -> ignored until busy falls, accepted one edge later; hi/lo reflect first then second product.
REQ-034 SHALL: reset pulsed low in cycle 3 of a mult -> busy=0, hi=lo=0 immediately and remain 0 after release; with DIVIDE_EN undefined, div request leaves busy=0 and hi/lo unchanged.
